// File: rtl/popcount_pkg.sv
// Shared constants and state encoding for the sliced popcount sequencer.
package popcount_pkg;

    localparam int SLICE_W = 15;
    localparam int OC_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/popcount_seq_ctrl_oc15.sv
// OC_15in: combinational ones counter, 15-bit input to 4-bit count.
import popcount_pkg::*;

module OC_15in (
    input  logic [SLICE_W-1:0] in_i,
    output logic [OC_W-1:0]    cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            cnt_o = cnt_o + OC_W'(in_i[i]);
        end
    end

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Sequencer that counts the ones in a wide word by feeding one 15-bit slice per
// clock through a single shared OC_15in and accumulating the partial counts.
import popcount_pkg::*;

module popcount_seq_ctrl #(
    parameter int SLICES = 4,
    parameter int CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SLICE_W*SLICES-1:0] data_in,
    input  logic                      ack,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count
);

    localparam int W     = SLICE_W * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    // The accumulator must hold the largest possible count without wrapping.
    if ((2 ** CNT_W) <= W) begin : g_cnt_w_too_small
        $error("popcount_seq_ctrl: CNT_W too small for 15*SLICES");
    end

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [CNT_W-1:0]   acc_q,    acc_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [SLICE_W-1:0] slice_w [SLICES];
    logic [SLICE_W-1:0] oc_in;
    logic [OC_W-1:0]    oc_cnt;
    logic [CNT_W-1:0]   oc_ext;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        assign slice_w[s] = shadow_q[s*SLICE_W +: SLICE_W];
    end

    assign oc_in  = slice_w[idx_q];
    assign oc_ext = CNT_W'(oc_cnt);

    OC_15in u_oc (
        .in_i  (oc_in),
        .cnt_o (oc_cnt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        shadow_d = shadow_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = data_in;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + oc_ext;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    count_d = acc_q + oc_ext;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A simultaneous ack+start chains straight into the next word.
                if (ack) begin
                    if (start) begin
                        shadow_d = data_in;
                        acc_d    = '0;
                        idx_d    = '0;
                        state_d  = S_RUN;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Directed, table-driven self-checking bench for popcount_seq_ctrl (SLICES=4).
module tb_popcount_seq_ctrl;

    localparam int SLICES = 4;
    localparam int CNT_W  = 6;
    localparam int W      = 15 * SLICES;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     data_in;
    logic             ack;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    int errors;
    int checks;

    typedef struct {
        logic [W-1:0]     data;
        logic [CNT_W-1:0] expCount;
        string            name;
    } vec_t;

    vec_t vecs[$];

    popcount_seq_ctrl #(.SLICES(SLICES), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all three outputs against the expected values.
    task automatic checkOutput(input string name, input logic expBusy,
                               input logic expDone, input logic [CNT_W-1:0] expCount);
        checks++;
        if (busy !== expBusy || done !== expDone || count !== expCount) begin
            errors++;
            $display("[TB] FAIL %s: got busy=%b done=%b count=%0d, expected busy=%b done=%b count=%0d",
                     name, busy, done, count, expBusy, expDone, expCount);
        end
    endtask

    // Drive inputs right after a rising edge so they are stable well before the next one.
    task automatic applyStimulus(input logic s, input logic a, input logic [W-1:0] d);
        start   = s;
        ack     = a;
        data_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a word from IDLE, check RUN lasts SLICES cycles, then ack back to IDLE.
    task automatic runWord(input logic [W-1:0] d, input logic [CNT_W-1:0] expCount,
                           input logic [CNT_W-1:0] oldCount, input string name);
        applyStimulus(1'b1, 1'b0, d);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput({name, "_accept"}, 1'b1, 1'b0, oldCount);
        for (int i = 1; i < SLICES; i++) begin
            tick();
            checkOutput({name, "_run"}, 1'b1, 1'b0, oldCount);
        end
        tick();
        checkOutput({name, "_done"}, 1'b0, 1'b1, expCount);
        applyStimulus(1'b0, 1'b1, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput({name, "_ack"}, 1'b0, 1'b0, expCount);
    endtask

    initial begin
        logic [CNT_W-1:0] prev;
        errors = 0;
        checks = 0;

        vecs.push_back('{60'h000000000000000, 6'd0,  "zero"});
        vecs.push_back('{60'hFFFFFFFFFFFFFFF, 6'd60, "all_ones"});
        vecs.push_back('{60'h000000000007FFF, 6'd15, "slice0_full"});
        vecs.push_back('{60'hFFFE00000000000, 6'd15, "slice3_full"});
        vecs.push_back('{60'h000000000000001, 6'd1,  "bit0"});
        vecs.push_back('{60'h800000000000000, 6'd1,  "bit59"});
        vecs.push_back('{60'h555555555555555, 6'd30, "alternating"});
        vecs.push_back('{60'h0123456789ABCDE, 6'd28, "hex_ramp"});

        // Reset state
        applyStimulus(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #12;
        checkOutput("reset", 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_no_start", 1'b0, 1'b0, 6'd0);

        prev = '0;
        foreach (vecs[i]) begin
            runWord(vecs[i].data, vecs[i].expCount, prev, vecs[i].name);
            prev = vecs[i].expCount;
        end

        // Start held high, data changed mid-RUN: only the first word counts, no re-run without ack.
        applyStimulus(1'b1, 1'b0, 60'h00000000000000F);
        tick();
        checkOutput("hold_accept", 1'b1, 1'b0, prev);
        for (int i = 1; i < SLICES; i++) begin
            applyStimulus(1'b1, 1'b0, 60'hFFFFFFFFFFFFFFF);
            tick();
            checkOutput("hold_run", 1'b1, 1'b0, prev);
        end
        tick();
        checkOutput("hold_done", 1'b0, 1'b1, 6'd4);
        tick();
        tick();
        checkOutput("hold_stay_done", 1'b0, 1'b1, 6'd4);

        // ack and start on the same edge: chain directly into a 7-ones word.
        applyStimulus(1'b1, 1'b1, 60'h00000000000007F);
        tick();
        applyStimulus(1'b0, 1'b0, 60'hFFFFFFFFFFFFFFF);
        checkOutput("chain_accept", 1'b1, 1'b0, 6'd4);
        for (int i = 1; i < SLICES; i++) begin
            tick();
            checkOutput("chain_run", 1'b1, 1'b0, 6'd4);
        end
        tick();
        checkOutput("chain_done", 1'b0, 1'b1, 6'd7);

        // Async reset in the middle of RUN (count is still 7 from the previous result).
        applyStimulus(1'b0, 1'b1, '0);
        tick();
        applyStimulus(1'b1, 1'b0, 60'hFFFFFFFFFFFFFFF);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        checkOutput("pre_reset_run", 1'b1, 1'b0, 6'd7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_idle", 1'b0, 1'b0, 6'd0);
        runWord(60'h0F0F0F0F0F0F0F0, 6'd28, 6'd0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
